// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS control sequencer with memory-ready wait and bus timeout.
// Optional MC_ILLEGAL_TRAP_EN: unsupported opcodes halt the FSM and assert illegal_op.
module mc_ctrl_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TO_W           = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       instr_done,
`ifdef MC_ILLEGAL_TRAP_EN
  output logic       illegal_op,
`endif
  output logic       bus_err
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB, ST_MEMWR,
    ST_EXEC, ST_ALUWB, ST_BRANCH, ST_ADDIEX, ST_ADDIWB, ST_JUMP, ST_HALT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [TO_W-1:0] r_wait_cnt;
  logic            w_in_wait;
  logic            w_expire;

  // Timeout only matters in states that wait on the memory handshake.
  assign w_in_wait = (r_state == ST_FETCH) || (r_state == ST_MEMRD) || (r_state == ST_MEMWR);
  assign w_expire  = (TIMEOUT_CYCLES != 0) && w_in_wait && !mem_ready &&
                     (r_wait_cnt == TO_W'(TIMEOUT_CYCLES));

`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal_op = (r_state == ST_HALT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_wait_cnt <= '0;
    else if (w_in_wait && !mem_ready && !w_expire) r_wait_cnt <= r_wait_cnt + TO_W'(1);
    else                                         r_wait_cnt <= '0;
  end

  always_comb begin
    w_next     = r_state;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    instr_done = 1'b0;
    bus_err    = w_expire;
    case (r_state)
      ST_IDLE: w_next = ST_FETCH;
      ST_FETCH: begin
        ALUSrcB    = 2'b01;
        ALUControl = ALU_ADD;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          w_next  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ALUSrcB    = 2'b11;
        ALUControl = ALU_ADD;
        case (Op)
          OP_RTYPE:     w_next = ST_EXEC;
          OP_LW, OP_SW: w_next = ST_MEMADR;
          OP_BEQ:       w_next = ST_BRANCH;
          OP_ADDI:      w_next = ST_ADDIEX;
          OP_J:         w_next = ST_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
          default:      w_next = ST_HALT;
`else
          default:      w_next = ST_FETCH;
`endif
        endcase
      end
      ST_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        w_next     = (Op == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        IorD = 1'b1;
        if (mem_ready)     w_next = ST_MEMWB;
        else if (w_expire) w_next = ST_FETCH;
      end
      ST_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = !w_expire;
        if (mem_ready) begin
          instr_done = 1'b1;
          w_next     = ST_FETCH;
        end else if (w_expire) begin
          w_next = ST_FETCH;
        end
      end
      ST_EXEC: begin
        ALUSrcA = 1'b1;
        case (Funct)
          6'b100010: ALUControl = ALU_SUB;
          6'b100100: ALUControl = ALU_AND;
          6'b100101: ALUControl = ALU_OR;
          6'b101010: ALUControl = ALU_SLT;
          default:   ALUControl = ALU_ADD;
        endcase
        w_next = ST_ALUWB;
      end
      ST_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = ALU_SUB;
        Branch     = 1'b1;
        PCSrc      = 2'b01;
        instr_done = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        w_next     = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_JUMP: begin
        PCSrc      = 2'b10;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: randomized check of mc_ctrl_fsm against a per-instruction step-script model.
// Build with +define+MC_ILLEGAL_TRAP_EN to exercise the halt-on-illegal-op variant.
module tb_mc_ctrl_fsm;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] Op = '0;
  logic [5:0] Funct = '0;
  logic       mem_ready = 1'b0;
  logic       IorD, MemWrite, IRWrite, PCWrite, Branch, ALUSrcA, RegDst, MemtoReg, RegWrite;
  logic       instr_done, bus_err;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUControl;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  mc_ctrl_fsm #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .instr_done(instr_done),
`ifdef MC_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Control word: [18]illegal [17]IorD [16]MemWrite [15]IRWrite [14]PCWrite [13]Branch
  // [12:11]PCSrc [10]ALUSrcA [9:8]ALUSrcB [7:5]ALUControl [4]RegDst [3]MemtoReg [2]RegWrite [1]done [0]bus_err
  typedef struct {
    logic [18:0] base;
    logic [18:0] rdy;
    bit          wt;
  } step_t;

  step_t       scr[$];
  bit          rdy_q[$];
  bit          rdy_mode = 1'b0;
  int          idx = 0;
  int          wcnt = 0;
  logic [5:0]  cur_op = '0;
  logic [5:0]  cur_fn = '0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cnt_iord, cnt_memw, cnt_irw, cnt_pcw, cnt_br, cnt_done, cnt_be;

  function automatic logic [18:0] cw(input logic iord, input logic mw, input logic irw,
                                     input logic pcw, input logic br, input logic [1:0] pcs,
                                     input logic asa, input logic [1:0] asb, input logic [2:0] alu,
                                     input logic rd, input logic m2r, input logic rw, input logic dn);
    return {1'b0, iord, mw, irw, pcw, br, pcs, asa, asb, alu, rd, m2r, rw, dn, 1'b0};
  endfunction

  function automatic logic [18:0] get_cw();
    logic il;
`ifdef MC_ILLEGAL_TRAP_EN
    il = illegal_op;
`else
    il = 1'b0;
`endif
    return {il, IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB,
            ALUControl, RegDst, MemtoReg, RegWrite, instr_done, bus_err};
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic step_t st(input logic [18:0] b, input logic [18:0] r, input bit w);
    step_t s;
    s.base = b; s.rdy = r; s.wt = w;
    return s;
  endfunction

  // Script of the cycles one instruction takes, from its fetch to its final cycle.
  task automatic build(input logic [5:0] op, input logic [5:0] fn);
    logic [18:0] adr;
    scr.delete();
    idx = 0; wcnt = 0;
    adr = cw(0,0,0,0,0,2'b00,1,2'b10,3'b010,0,0,0,0);
    scr.push_back(st(cw(0,0,0,0,0,2'b00,0,2'b01,3'b010,0,0,0,0),
                     cw(0,0,1,1,0,2'b00,0,2'b01,3'b010,0,0,0,0), 1'b1));
    scr.push_back(st(cw(0,0,0,0,0,2'b00,0,2'b11,3'b010,0,0,0,0), '0, 1'b0));
    case (op)
      6'b000000: begin
        scr.push_back(st(cw(0,0,0,0,0,2'b00,1,2'b00,alu_of(fn),0,0,0,0), '0, 1'b0));
        scr.push_back(st(cw(0,0,0,0,0,2'b00,0,2'b00,3'b000,1,0,1,1), '0, 1'b0));
      end
      6'b100011: begin
        scr.push_back(st(adr, '0, 1'b0));
        scr.push_back(st(cw(1,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0),
                         cw(1,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0), 1'b1));
        scr.push_back(st(cw(0,0,0,0,0,2'b00,0,2'b00,3'b000,0,1,1,1), '0, 1'b0));
      end
      6'b101011: begin
        scr.push_back(st(adr, '0, 1'b0));
        scr.push_back(st(cw(1,1,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,0),
                         cw(1,1,0,0,0,2'b00,0,2'b00,3'b000,0,0,0,1), 1'b1));
      end
      6'b000100:
        scr.push_back(st(cw(0,0,0,0,1,2'b01,1,2'b00,3'b110,0,0,0,1), '0, 1'b0));
      6'b001000: begin
        scr.push_back(st(adr, '0, 1'b0));
        scr.push_back(st(cw(0,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,1,1), '0, 1'b0));
      end
      6'b000010:
        scr.push_back(st(cw(0,0,0,1,0,2'b10,0,2'b00,3'b000,0,0,0,1), '0, 1'b0));
      default: ;
    endcase
  endtask

  function automatic bit next_ready();
    if (rdy_q.size() != 0) return rdy_q.pop_front();
    if (rdy_mode) return ($urandom_range(0, 3) != 0);
    return 1'b1;
  endfunction

  // One clock of stimulus and comparison against the current script step.
  task automatic model_cycle(input bit r, input string tag);
    step_t       s;
    logic [18:0] exp, got;
    @(negedge clk);
    mem_ready = r; Op = cur_op; Funct = cur_fn;
    #1;
    s = scr[idx];
    if (!s.wt) begin
      exp = s.base; idx++; wcnt = 0;
    end else if (r) begin
      exp = s.rdy; idx++; wcnt = 0;
    end else if (wcnt == TO) begin
      exp = (s.base & ~19'h10000) | 19'h1; idx = 0; wcnt = 0;
    end else begin
      exp = s.base; wcnt++;
    end
    got = get_cw();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cw op=%b rdy=%0d got=%b exp=%b t=%0t", tag, cur_op, r, got, exp, $time);
    end
    cnt_iord += int'(got[17]); cnt_memw += int'(got[16]); cnt_irw += int'(got[15]);
    cnt_pcw  += int'(got[14]); cnt_br   += int'(got[13]); cnt_done += int'(got[1]);
    cnt_be   += int'(got[0]);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input string tag,
                           output int ncyc);
    cur_op = op; cur_fn = fn;
    build(op, fn);
    ncyc = 0;
    cnt_iord = 0; cnt_memw = 0; cnt_irw = 0; cnt_pcw = 0; cnt_br = 0; cnt_done = 0; cnt_be = 0;
    while (idx < scr.size() && ncyc < 200) begin
      model_cycle(next_ready(), tag);
      ncyc++;
    end
    if (idx < scr.size()) begin
      n_cmp++; n_bad++;
      $display("FAIL %s bound: got %0d cycles without completion, required <200", tag, ncyc);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_cmp++;
    if (get_cw() !== 19'd0) begin
      n_bad++;
      $display("FAIL idle_cycle got=%b exp=0", get_cw());
    end
    scr.delete(); idx = 0; wcnt = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (get_cw() !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_async got=%b exp=0", get_cw());
    end
    release_reset();
  endtask

  task automatic test_latency();
    int n;
    logic [5:0] ops[6];
    int lat[6];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    lat = '{4, 5, 4, 3, 4, 3};
    rdy_mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_instr(ops[i], 6'b100010, "latency", n);
      check_int($sformatf("latency_op%b", ops[i]), n, lat[i]);
      check_int($sformatf("done_op%b", ops[i]), cnt_done, 1);
    end
  endtask

  task automatic test_lw_wait();
    int n;
    rdy_q = '{1, 1, 1, 0, 0, 0, 1};
    run_instr(6'b100011, 6'b000000, "lw_wait", n);
    check_int("lw_wait_cycles", n, 8);
    check_int("lw_wait_iord", cnt_iord, 4);
  endtask

  task automatic test_back_to_back();
    int n, done_t, mw_t, br_t, pcw_t;
    done_t = 0; mw_t = 0; br_t = 0; pcw_t = 0;
    run_instr(6'b101011, 6'b000000, "b2b_sw", n);
    done_t += cnt_done; mw_t += cnt_memw; br_t += cnt_br; pcw_t += cnt_pcw;
    run_instr(6'b000100, 6'b000000, "b2b_beq", n);
    done_t += cnt_done; mw_t += cnt_memw; br_t += cnt_br; pcw_t += cnt_pcw;
    run_instr(6'b000010, 6'b000000, "b2b_j", n);
    done_t += cnt_done; mw_t += cnt_memw; br_t += cnt_br; pcw_t += cnt_pcw;
    check_int("b2b_done", done_t, 3);
    check_int("b2b_memwrite", mw_t, 1);
    check_int("b2b_branch", br_t, 1);
    check_int("b2b_pcwrite", pcw_t, 4);
  endtask

  task automatic test_timeout();
    int n;
    rdy_q.delete();
    for (int i = 0; i < 17; i++) rdy_q.push_back(1'b0);
    run_instr(6'b001000, 6'b000000, "to_fetch", n);
    check_int("to_fetch_buserr", cnt_be, 1);
    check_int("to_fetch_irwrite", cnt_irw, 1);
    check_int("to_fetch_cycles", n, 21);
    rdy_q.delete();
    for (int i = 0; i < 16; i++) rdy_q.push_back(1'b0);
    run_instr(6'b001000, 6'b000000, "to_edge", n);
    check_int("to_edge_buserr", cnt_be, 0);
    check_int("to_edge_cycles", n, 20);
    rdy_q = '{1, 1, 1};
    for (int i = 0; i < 17; i++) rdy_q.push_back(1'b0);
    run_instr(6'b101011, 6'b000000, "to_memwr", n);
    check_int("to_memwr_buserr", cnt_be, 1);
    check_int("to_memwr_memwrite", cnt_memw, 17);
    check_int("to_memwr_done", cnt_done, 1);
  endtask

  task automatic test_reset_mid();
    int n;
    cur_op = 6'b101011; cur_fn = '0;
    build(cur_op, cur_fn);
    for (int i = 0; i < 3; i++) model_cycle(1'b1, "rst_mid");
    model_cycle(1'b0, "rst_mid");
    check_int("rst_mid_memwrite_pre", int'(MemWrite), 1);
    #1 rst_n = 1'b0;
    #1;
    check_int("rst_mid_memwrite_async", int'(MemWrite), 0);
    n_cmp++;
    if (get_cw() !== 19'd0) begin
      n_bad++;
      $display("FAIL rst_mid_allzero got=%b exp=0", get_cw());
    end
    release_reset();
    run_instr(6'b000000, 6'b100101, "rst_mid_resume", n);
    check_int("rst_mid_resume_cycles", n, 4);
  endtask

  task automatic test_illegal();
    int n;
    rdy_mode = 1'b0;
    run_instr(6'b111111, 6'b000000, "illegal", n);
    check_int("illegal_cycles", n, 2);
    check_int("illegal_done", cnt_done, 0);
`ifdef MC_ILLEGAL_TRAP_EN
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if (get_cw() !== 19'h40000) begin
        n_bad++;
        $display("FAIL halt_hold got=%b exp=%b", get_cw(), 19'h40000);
      end
    end
    test_reset();
`else
    run_instr(6'b001000, 6'b000000, "illegal_next", n);
    check_int("illegal_next_cycles", n, 4);
`endif
  endtask

  task automatic test_random();
    int n, k;
    logic [5:0] op;
    rdy_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
`ifdef MC_ILLEGAL_TRAP_EN
      k = $urandom_range(0, 5);
`else
      k = $urandom_range(0, 6);
`endif
      case (k)
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b000010;
        default: op = 6'b010101;
      endcase
      if ($urandom_range(0, 7) == 0)
        for (int j = 0; j < 17; j++) rdy_q.push_back(1'b0);
      run_instr(op, 6'($urandom_range(0, 63)), "random", n);
      check_int("random_done", cnt_done, (k == 6) ? 0 : 1);
    end
    rdy_mode = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_lw_wait();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle sequencer for the single-memory MIPS datapath: one instruction is stepped through fetch, decode, execute, memory and writeback states.
- Drives every datapath enable and mux select each cycle, and waits on a memory ready handshake.
- Supported opcodes: R-type (add/sub/and/or/slt), lw, sw, beq, addi, j.
- Sits between the instruction register (Op/Funct) and the shared datapath/memory.

Parameters:
TIMEOUT_CYCLES, 16, consecutive mem_ready-low wait cycles before a bus error abort; 0 disables the timeout.
TO_W, 5, width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
Op  input  6  opcode from instruction register
Funct  input  6  funct field from instruction register
mem_ready  input  1  memory completes current access this cycle
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register load
PCWrite  output  1  unconditional PC load
Branch  output  1  PC load qualified by ALU zero
PCSrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
ALUSrcA  output  1  0=PC, 1=A register
ALUSrcB  output  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
ALUControl  output  3  ADD=010, SUB=110, AND=000, OR=001, SLT=111
RegDst  output  1  0=rt, 1=rd
MemtoReg  output  1  0=ALUOut, 1=memory data register
RegWrite  output  1  register file write enable
instr_done  output  1  one-cycle pulse in the final cycle of a completed instruction
bus_err  output  1  one-cycle pulse on memory timeout abort

Behaviour:
- Reset: rst_n low forces state IDLE asynchronously. In IDLE every output is 0 (ALUControl=000, PCSrc=00, ALUSrcB=00). First rising edge after release goes IDLE->FETCH.
- Outputs are decoded from the state register. Exceptions gated by mem_ready (Mealy): IRWrite/PCWrite in FETCH, and the leave condition of the wait states. Signals not listed for a state are 0.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, PCSrc=00, IRWrite=PCWrite=mem_ready. mem_ready=1 -> DECODE; otherwise hold.
- DECODE: ALUSrcA=0, ALUSrcB=11, ADD (precompute branch target). Transitions by Op:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other -> FETCH (illegal-op handling under the optional feature).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Op=100011 -> MEMRD, else -> MEMWR.
- MEMRD: IorD=1. Hold until mem_ready, then -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1 held every cycle until mem_ready. On mem_ready: instr_done=1 -> FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00. ALUControl from Funct:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT
  - other Funct -> ADD
  - next state -> ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, Branch=1, PCSrc=01, instr_done=1 -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD -> ADDIWB.
- ADDIWB: RegDst=0, RegWrite=1, instr_done=1 -> FETCH.
- JUMP: PCSrc=10, PCWrite=1, instr_done=1 -> FETCH.
- Latency with mem_ready tied 1: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3 cycles.
- Timeout:
  - Wait counter increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0, and clears on any state change or on mem_ready=1.
  - When the counter reaches TIMEOUT_CYCLES with mem_ready still 0, that cycle pulses bus_err=1. IRWrite, PCWrite, MemWrite and instr_done are 0 in that cycle, and the FSM goes to FETCH (PC not advanced, instruction refetched).
  - mem_ready=1 in the same cycle as expiry wins: normal completion, no bus_err.
- Reset mid-instruction: immediate IDLE, all strobes drop asynchronously, no partial writeback.

Optional Feature:
MC_ILLEGAL_TRAP_EN
- Defined: an unsupported Op in DECODE -> HALT state. In HALT, output illegal_op (1 bit, extra port) is held 1 and all other outputs are 0. HALT is left only by reset.
- Undefined: no illegal_op port. An unsupported Op is a 2-cycle no-op (DECODE->FETCH) with no instr_done.

Test Plan:
- Reset release, mem_ready=1, Op=000000, Funct=100010 -> cycle 1 IDLE all 0; FETCH IRWrite=PCWrite=1; EXEC ALUControl=110; ALUWB RegWrite=1, RegDst=1, instr_done=1.
- lw (Op=100011), mem_ready low 3 cycles in MEMRD -> IorD=1 held 4 cycles; MEMWB MemtoReg=1, RegWrite=1; total 8 cycles.
- sw, then beq, then j back-to-back -> MemWrite=1 only in MEMWR; Branch=1/PCSrc=01/ALUControl=110 in BRANCH; PCWrite=1/PCSrc=10 in JUMP; instr_done pulses exactly 3 times.
- mem_ready stuck 0 in FETCH, TIMEOUT_CYCLES=16 -> bus_err pulses once after 16 wait cycles; IRWrite never 1; FSM restarts FETCH; ready arriving at expiry cycle -> no bus_err.
- rst_n driven low during MEMWR with MemWrite=1 -> MemWrite falls without a clock edge; resumes from IDLE->FETCH.
- Op=111111 -> with MC_ILLEGAL_TRAP_EN illegal_op=1 held until reset; without it FETCH after DECODE, no instr_done.
